// File: rtl/dro_bank.sv
// N-channel clocked model of a destructive-readout cell bank with toggle-encoded I/O and hold checkers.
// Optional macro DRO_BANK_VIOL_CNT_EN adds the saturating viol_cnt violation counter.
module dro_bank #(
    parameter int N        = 4,
    parameter int INIT_CYC = 8,
    parameter int OUT_DLY  = 3,
    parameter int HOLD_SR  = 2,
    parameter int HOLD_RS  = 2
`ifdef DRO_BANK_VIOL_CNT_EN
    ,
    parameter int CNT_W    = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     set,
    input  logic [N-1:0]     reset,
    output logic [N-1:0]     out,
    output logic             armed,
    input  logic             viol_clr,
    output logic [N-1:0]     viol
`ifdef DRO_BANK_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0] viol_cnt
`endif
);

    localparam int IC_W = $clog2(INIT_CYC + 1);
    localparam int SR_W = $clog2(HOLD_SR + 1);
    localparam int RS_W = $clog2(HOLD_RS + 1);

    typedef enum logic [1:0] {
        UNINIT = 2'd0,
        EMPTY  = 2'd1,
        STORED = 2'd2
    } state_t;

    logic [N-1:0]    set_q;
    logic [N-1:0]    reset_q;
    logic [N-1:0]    sp;
    logic [N-1:0]    rp;
    logic [N-1:0]    tq;
    logic [N-1:0]    flag;
    logic [N-1:0]    tap;
    logic [IC_W-1:0] init_cnt;
    logic            init_done;
    state_t          st     [N];
    state_t          st_nxt [N];
    logic [SR_W-1:0] sr_tmr [N];
    logic [RS_W-1:0] rs_tmr [N];

    assign sp        = set ^ set_q;
    assign rp        = reset ^ reset_q;
    assign init_done = !armed && (init_cnt == IC_W'(INIT_CYC - 1));

    // Edge detect, init window, sticky flags and the output toggle flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q    <= '0;
            reset_q  <= '0;
            init_cnt <= '0;
            armed    <= 1'b0;
            viol     <= '0;
            out      <= '0;
        end else begin
            set_q   <= set;
            reset_q <= reset;
            if (init_done) begin
                armed <= 1'b1;
            end else if (!armed) begin
                init_cnt <= init_cnt + IC_W'(1);
            end
            // a fresh violation wins over a same-cycle clear
            viol <= (viol & ~{N{viol_clr}}) | flag;
            out  <= out ^ tap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                st[i]     <= UNINIT;
                sr_tmr[i] <= '0;
                rs_tmr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                st[i] <= st_nxt[i];
                if (st[i] != UNINIT && sp[i]) begin
                    sr_tmr[i] <= SR_W'(HOLD_SR - 1);
                end else if (sr_tmr[i] != '0) begin
                    sr_tmr[i] <= sr_tmr[i] - SR_W'(1);
                end
                // only a read of an empty cell opens the set-after-reset window
                if (st[i] == EMPTY && rp[i]) begin
                    rs_tmr[i] <= RS_W'(HOLD_RS - 1);
                end else if (rs_tmr[i] != '0) begin
                    rs_tmr[i] <= rs_tmr[i] - RS_W'(1);
                end
            end
        end
    end

    always_comb begin
        tq   = '0;
        flag = '0;
        for (int i = 0; i < N; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                UNINIT: begin
                    if (init_done) st_nxt[i] = EMPTY;
                end
                EMPTY: begin
                    if (sp[i] && rp[i]) begin
                        tq[i] = 1'b1;
                    end else if (sp[i]) begin
                        st_nxt[i] = STORED;
                    end
                end
                STORED: begin
                    if (rp[i]) begin
                        st_nxt[i] = EMPTY;
                        tq[i]     = 1'b1;
                    end
                end
                default: st_nxt[i] = UNINIT;
            endcase
            if (st[i] != UNINIT) begin
                flag[i] = (rp[i] && (sp[i] || sr_tmr[i] != '0)) ||
                          (sp[i] && rs_tmr[i] != '0);
            end
        end
    end

    // Readout delay: OUT_DLY-1 register stages ahead of the output toggle flop
    generate
        if (OUT_DLY == 1) begin : g_nodly
            assign tap = tq;
        end else begin : g_dly
            logic [N-1:0] dly_p [OUT_DLY-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < OUT_DLY - 1; k++) dly_p[k] <= '0;
                end else begin
                    dly_p[0] <= tq;
                    for (int k = 1; k < OUT_DLY - 1; k++) dly_p[k] <= dly_p[k-1];
                end
            end
            assign tap = dly_p[OUT_DLY-2];
        end
    endgenerate

`ifdef DRO_BANK_VIOL_CNT_EN
    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = CNT_W + PC_W;

    function automatic logic [PC_W-1:0] popcnt(input logic [N-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) c = c + PC_W'(v[k]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        logic [CNT_W-1:0] r;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}})) r = {CNT_W{1'b1}};
        else                           r = s[CNT_W-1:0];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt <= '0;
        end else begin
            viol_cnt <= sat_add(viol_clr ? '0 : viol_cnt, popcnt(flag));
        end
    end
`endif

endmodule

// File: tb/tb_dro_bank.sv
// Scoreboard bench for dro_bank: expected out toggles are queued at drive time and
// matched against observed toggles; flags, armed and counter are checked directly.
module tb_dro_bank;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] set;
    logic [N-1:0] reset;
    logic [N-1:0] out;
    logic         armed;
    logic         viol_clr;
    logic [N-1:0] viol;
`ifdef DRO_BANK_VIOL_CNT_EN
    logic [1:0]   viol_cnt;
`endif

    always #5 clk = ~clk;

`ifdef DRO_BANK_VIOL_CNT_EN
    dro_bank #(.N(N), .INIT_CYC(8), .OUT_DLY(3), .HOLD_SR(2), .HOLD_RS(2), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .out(out), .armed(armed),
        .viol_clr(viol_clr), .viol(viol), .viol_cnt(viol_cnt)
    );
`else
    dro_bank #(.N(N), .INIT_CYC(8), .OUT_DLY(3), .HOLD_SR(2), .HOLD_RS(2)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .reset(reset), .out(out), .armed(armed),
        .viol_clr(viol_clr), .viol(viol)
    );
`endif

    typedef struct {
        int ch;
        int due;
    } exp_t;

    exp_t         sb [$];
    int           cyc;
    int           n_chk;
    int           n_fail;
    logic [N-1:0] prev_out;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    // Advance one clock, sample #1 after the edge and reconcile out toggles with the queue
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check_eq($sformatf("tgl_missing_ch%0d", e.ch), cyc, e.due);
        end
        for (int c = 0; c < N; c++) begin
            if (out[c] !== prev_out[c]) begin
                if (sb.size() == 0) begin
                    check_eq("tgl_unexpected", 32'(out), 32'(prev_out));
                end else begin
                    e = sb.pop_front();
                    check_eq("tgl_ch", c, e.ch);
                    check_eq("tgl_cyc", cyc, e.due);
                end
            end
        end
        prev_out = out;
    endtask

    task automatic expect_tgl(input int ch);
        exp_t e;
        e.ch  = ch;
        e.due = cyc + 3;
        sb.push_back(e);
    endtask

    initial begin
        cyc      = 0;
        n_chk    = 0;
        n_fail   = 0;
        prev_out = '0;
        rst_n    = 1'b0;
        set      = '0;
        reset    = '0;
        viol_clr = 1'b0;

        // reset values
        repeat (3) tick();
        check_eq("rst_out", 32'(out), 0);
        check_eq("rst_armed", 32'(armed), 0);
        check_eq("rst_viol", 32'(viol), 0);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("rst_cnt", 32'(viol_cnt), 0);
`endif

        // init window: set[0] while UNINIT is discarded
        rst_n = 1'b1;
        tick();
        set[0] = ~set[0];
        repeat (6) tick();
        check_eq("t1_armed_c7", 32'(armed), 0);
        tick();
        check_eq("t1_armed_c8", 32'(armed), 1);
        repeat (2) tick();
        reset[0] = ~reset[0];
        repeat (4) tick();
        check_eq("t1_out", 32'(out), 0);
        check_eq("t1_viol", 32'(viol), 0);

        // clean store then read, second read finds the cell empty
        set[1] = ~set[1];
        repeat (5) tick();
        reset[1] = ~reset[1];
        expect_tgl(1);
        repeat (4) tick();
        check_eq("t2_out", 32'(out), 32'h2);
        check_eq("t2_viol", 32'(viol), 0);
        reset[1] = ~reset[1];
        repeat (4) tick();
        check_eq("t2_out_empty", 32'(out), 32'h2);
        check_eq("t2_viol_empty", 32'(viol), 0);

        // set->reset hold violation, readout still happens
        set[2] = ~set[2];
        tick();
        reset[2] = ~reset[2];
        expect_tgl(2);
        tick();
        check_eq("t3_viol", 32'(viol), 32'h4);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("t3_cnt", 32'(viol_cnt), 1);
`endif
        repeat (3) tick();
        check_eq("t3_out", 32'(out), 32'h6);
        check_eq("t3_sticky", 32'(viol), 32'h4);
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        check_eq("t3_clr", 32'(viol), 0);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("t3_cnt_clr", 32'(viol_cnt), 0);
`endif
        repeat (2) tick();

        // reset->set hold violation from EMPTY; the set is still stored
        reset[3] = ~reset[3];
        tick();
        set[3] = ~set[3];
        tick();
        check_eq("t4_viol", 32'(viol), 32'h8);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("t4_cnt", 32'(viol_cnt), 1);
`endif
        repeat (3) tick();
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        reset[3] = ~reset[3];
        expect_tgl(3);
        tick();
        set[3] = ~set[3];
        repeat (4) tick();
        check_eq("t4_viol_stored", 32'(viol), 0);
        check_eq("t4_out", 32'(out), 32'he);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("t4_cnt_clr", 32'(viol_cnt), 0);
`endif

        // same-cycle set+reset in EMPTY: flag plus set-then-read toggle
        set[0]   = ~set[0];
        reset[0] = ~reset[0];
        expect_tgl(0);
        tick();
        check_eq("t5_viol", 32'(viol), 32'h1);
        repeat (3) tick();
        check_eq("t5_out", 32'(out), 32'hf);
        repeat (2) tick();
        reset[0] = ~reset[0];
        repeat (4) tick();
        check_eq("t5_empty_out", 32'(out), 32'hf);
        check_eq("t5_empty_viol", 32'(viol), 32'h1);

        // five violations in two batches, then reset with a toggle in flight
        viol_clr = 1'b1;
        tick();
        viol_clr = 1'b0;
        check_eq("t6_clr", 32'(viol), 0);
        for (int c = 0; c < 3; c++) begin
            set[c]   = ~set[c];
            reset[c] = ~reset[c];
            expect_tgl(c);
        end
        tick();
        check_eq("t6_viol_b1", 32'(viol), 32'h7);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("t6_cnt_b1", 32'(viol_cnt), 3);
`endif
        repeat (3) tick();
        for (int c = 0; c < 2; c++) begin
            set[c]   = ~set[c];
            reset[c] = ~reset[c];
            expect_tgl(c);
        end
        tick();
        check_eq("t6_viol_b2", 32'(viol), 32'h7);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("t6_cnt_sat", 32'(viol_cnt), 3);
`endif
        repeat (4) tick();
        check_eq("t6_out", 32'(out), 32'hb);
        reset[3] = ~reset[3];
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_out", 32'(out), 0);
        check_eq("t6_rst_viol", 32'(viol), 0);
        check_eq("t6_rst_armed", 32'(armed), 0);
`ifdef DRO_BANK_VIOL_CNT_EN
        check_eq("t6_rst_cnt", 32'(viol_cnt), 0);
`endif
        prev_out = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (7) tick();
        check_eq("t6_rearm_c7", 32'(armed), 0);
        tick();
        check_eq("t6_rearm_c8", 32'(armed), 1);
        repeat (5) tick();
        check_eq("t6_pipe_dropped", 32'(out), 0);
        check_eq("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
